// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
//  Module      : writeback
//  Description : Register-file write-back stage. Buffers retired results in
//                a small FIFO, formats the write data per instruction class
//                and presents a stable data/rd word with a single-cycle
//                strobe (setup / strobe / hold) to the register file write
//                port. Also counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  input  logic [4:0]  itype_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] mem_i,
  input  logic [31:0] pc_i,
  output logic [31:0] wd_o,
  output logic [4:0]  wd_rd_o,
  output logic        wd_q_o,
  output logic        busy_o,
  output logic [31:0] retire_cnt_o
);

  // Instruction-class encodings shared with the execute stage.
  localparam logic [4:0] RTYPE  = 5'd1;
  localparam logic [4:0] ITYPE  = 5'd2;
  localparam logic [4:0] STYPE  = 5'd3;
  localparam logic [4:0] BTYPE  = 5'd4;
  localparam logic [4:0] LTYPE  = 5'd5;
  localparam logic [4:0] UTYPE  = 5'd6;
  localparam logic [4:0] JTYPE  = 5'd7;
  localparam logic [4:0] JRTYPE = 5'd8;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]  itype;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  entry_t           store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Head decode
  entry_t           head;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [31:0]      write_data;
  logic             write_en;

  // FSM
  state_t           state;
  state_t           next_state;
  logic             load_wd;
  logic             strobe_next;
  logic             retire;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Ready depends only on registered occupancy: a full FIFO refuses a push
  // even when the head is leaving in the same cycle.
  assign res_ready_o = reset && !full;
  assign push        = res_valid_i && res_ready_o;
  assign busy_o      = !empty || (state != IDLE);

  // FIFO payload write; entries beyond the pointers are don't-care, so the
  // array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= '{itype: itype_i, rd: rd_i, funct3: funct3_i,
                         alu: alu_i, mem: mem_i, pc: pc_i};
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Select and format the write data for the FIFO head
  always_comb begin
    head       = store[rd_ptr];
    load_byte  = head.mem[{head.alu[1:0], 3'b000} +: 8];
    load_half  = head.mem[{head.alu[1], 4'b0000} +: 16];
    write_data = head.alu;
    write_en   = 1'b0;
    case (head.itype)
      RTYPE, ITYPE, UTYPE: begin
        write_data = head.alu;
        write_en   = 1'b1;
      end
      JTYPE, JRTYPE: begin
        write_data = head.pc + 32'd4;
        write_en   = 1'b1;
      end
      LTYPE: begin
        write_en = 1'b1;
        case (head.funct3)
          3'b000:  write_data = {{24{load_byte[7]}}, load_byte};
          3'b001:  write_data = {{16{load_half[15]}}, load_half};
          3'b100:  write_data = {24'd0, load_byte};
          3'b101:  write_data = {16'd0, load_half};
          default: write_data = head.mem;
        endcase
      end
      STYPE, BTYPE: write_en = 1'b0;
      default:      write_en = 1'b0;
    endcase
    // x0 is hard-wired zero: never write it.
    if (head.rd == 5'd0) begin
      write_en = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state and control strobes
  always_comb begin
    next_state  = state;
    pop         = 1'b0;
    load_wd     = 1'b0;
    strobe_next = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (write_en) begin
            load_wd    = 1'b1;
            next_state = SETUP;
          end else begin
            // Non-writing entries retire immediately, one per cycle.
            retire = 1'b1;
          end
        end
      end
      SETUP: begin
        strobe_next = 1'b1;
        next_state  = STROBE;
      end
      STROBE: begin
        retire     = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Register-file port outputs and retire counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_o         <= '0;
      wd_rd_o      <= '0;
      wd_q_o       <= 1'b0;
      retire_cnt_o <= '0;
    end else begin
      if (load_wd) begin
        wd_o    <= write_data;
        wd_rd_o <= head.rd;
      end
      // Registered strobe: high only while the FSM sits in STROBE.
      wd_q_o <= strobe_next;
      if (retire) begin
        retire_cnt_o <= retire_cnt_o + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback.sv
`timescale 1ns/1ps
`default_nettype none
module tb_writeback;

  localparam logic [4:0] RTYPE  = 5'd1;
  localparam logic [4:0] ITYPE  = 5'd2;
  localparam logic [4:0] STYPE  = 5'd3;
  localparam logic [4:0] BTYPE  = 5'd4;
  localparam logic [4:0] LTYPE  = 5'd5;
  localparam logic [4:0] UTYPE  = 5'd6;
  localparam logic [4:0] JTYPE  = 5'd7;
  localparam logic [4:0] JRTYPE = 5'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [4:0]  itype_i;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_i;
  logic [31:0] mem_i;
  logic [31:0] pc_i;
  logic [31:0] wd_o;
  logic [4:0]  wd_rd_o;
  logic        wd_q_o;
  logic        busy_o;
  logic [31:0] retire_cnt_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  writeback #(.DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .res_valid_i  (res_valid_i),
    .res_ready_o  (res_ready_o),
    .itype_i      (itype_i),
    .rd_i         (rd_i),
    .funct3_i     (funct3_i),
    .alu_i        (alu_i),
    .mem_i        (mem_i),
    .pc_i         (pc_i),
    .wd_o         (wd_o),
    .wd_rd_o      (wd_rd_o),
    .wd_q_o       (wd_q_o),
    .busy_o       (busy_o),
    .retire_cnt_o (retire_cnt_o)
  );

  // Data-select vectors: itype, rd, funct3, alu, mem, pc, expected wd_o
  logic [4:0]  v_it  [12] = '{LTYPE, LTYPE, LTYPE, LTYPE, LTYPE, LTYPE,
                              LTYPE, LTYPE, JTYPE, JRTYPE, UTYPE, ITYPE};
  logic [4:0]  v_rd  [12] = '{5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                              5'd12, 5'd13, 5'd1, 5'd31, 5'd2, 5'd3};
  logic [2:0]  v_f3  [12] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001, 3'b010,
                              3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [31:0] v_alu [12] = '{32'h0000_1003, 32'h0000_1003, 32'h0000_2002,
                              32'h0000_2002, 32'h0000_2000, 32'h0000_0003,
                              32'h0000_0001, 32'h0000_0000, 32'h0000_0055,
                              32'h0000_0077, 32'hABCD_E000, 32'hFFFF_FFFF};
  logic [31:0] v_mem [12] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                              32'h80FF_0000, 32'h80FF_7F01, 32'hDEAD_BEEF,
                              32'h0000_8100, 32'h1234_5678, 32'h0,
                              32'h0, 32'h0, 32'h0};
  logic [31:0] v_pc  [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0100,
                              32'h0, 32'h0};
  logic [31:0] v_exp [12] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF,
                              32'hFFFF_80FF, 32'h0000_7F01, 32'hDEAD_BEEF,
                              32'hFFFF_FF81, 32'h1234_5678, 32'h0000_0000,
                              32'h0000_0104, 32'hABCD_E000, 32'hFFFF_FFFF};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] it, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc);
    res_valid_i = v;
    itype_i     = it;
    rd_i        = rd;
    funct3_i    = f3;
    alu_i       = alu;
    mem_i       = mem;
    pc_i        = pc;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    step();
    step();
    checks++;
    if ({wd_o, wd_rd_o, wd_q_o, retire_cnt_o} !== 70'd0) begin
      errors++;
      $display("FAIL reset_outputs: wd=%h rd=%0d q=%b cnt=%0d, want all zero",
               wd_o, wd_rd_o, wd_q_o, retire_cnt_o);
    end
    checks++;
    if (res_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_busy: ready=%b busy=%b, want 0 0", res_ready_o, busy_o);
    end
    reset = 1'b1;
    step();
    checks++;
    if (res_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: ready=%b, want 1", res_ready_o);
    end
  endtask

  task automatic test_rtype();
    drive(1'b1, RTYPE, 5'd5, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
    step();
    drive(1'b0, 5'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    checks++;
    if (wd_q_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rtype_pop_cycle: q=%b busy=%b, want 0 1", wd_q_o, busy_o);
    end
    step();
    checks++;
    if (wd_o !== 32'h1234_5678 || wd_rd_o !== 5'd5 || wd_q_o !== 1'b0) begin
      errors++;
      $display("FAIL rtype_setup: wd=%h rd=%0d q=%b, want 12345678 5 0", wd_o, wd_rd_o, wd_q_o);
    end
    step();
    checks++;
    if (wd_q_o !== 1'b1 || retire_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL rtype_strobe: q=%b cnt=%0d, want 1 0", wd_q_o, retire_cnt_o);
    end
    step();
    checks++;
    if (wd_q_o !== 1'b0 || retire_cnt_o !== 32'd1 || wd_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rtype_hold: q=%b cnt=%0d wd=%h, want 0 1 12345678", wd_q_o, retire_cnt_o, wd_o);
    end
    step();
    exp_cnt = 32'd1;
    checks++;
    if (busy_o !== 1'b0 || wd_q_o !== 1'b0 || wd_rd_o !== 5'd5) begin
      errors++;
      $display("FAIL rtype_idle: busy=%b q=%b rd=%0d, want 0 0 5", busy_o, wd_q_o, wd_rd_o);
    end
  endtask

  task automatic test_data_select();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, v_it[i], v_rd[i], v_f3[i], v_alu[i], v_mem[i], v_pc[i]);
      step();
      drive(1'b0, 5'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
      step();
      checks++;
      if (wd_o !== v_exp[i] || wd_rd_o !== v_rd[i] || wd_q_o !== 1'b0) begin
        errors++;
        $display("FAIL select_setup[%0d]: wd=%h rd=%0d q=%b, want %h %0d 0",
                 i, wd_o, wd_rd_o, wd_q_o, v_exp[i], v_rd[i]);
      end
      step();
      checks++;
      if (wd_q_o !== 1'b1 || wd_o !== v_exp[i]) begin
        errors++;
        $display("FAIL select_strobe[%0d]: q=%b wd=%h, want 1 %h", i, wd_q_o, wd_o, v_exp[i]);
      end
      step();
      exp_cnt = exp_cnt + 32'd1;
      checks++;
      if (wd_q_o !== 1'b0 || retire_cnt_o !== exp_cnt) begin
        errors++;
        $display("FAIL select_hold[%0d]: q=%b cnt=%0d, want 0 %0d", i, wd_q_o, retire_cnt_o, exp_cnt);
      end
      step();
    end
  endtask

  task automatic test_no_write();
    logic [4:0]  nw_it [5] = '{BTYPE, ITYPE, STYPE, 5'd31, RTYPE};
    logic [4:0]  nw_rd [5] = '{5'd3, 5'd0, 5'd7, 5'd9, 5'd0};
    logic [31:0] base = exp_cnt;
    logic [31:0] last_wd = wd_o;
    logic [4:0]  last_rd = wd_rd_o;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (res_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL nowrite_ready[%0d]: ready=%b, want 1", k, res_ready_o);
      end
      drive(1'b1, nw_it[k], nw_rd[k], 3'd0, 32'hCAFE_0000 + k, 32'h0, 32'h0);
      step();
      checks++;
      if (wd_q_o !== 1'b0 || retire_cnt_o !== base + k) begin
        errors++;
        $display("FAIL nowrite_step[%0d]: q=%b cnt=%0d, want 0 %0d", k, wd_q_o, retire_cnt_o, base + k);
      end
    end
    drive(1'b0, 5'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    step();
    exp_cnt = base + 32'd5;
    checks++;
    if (retire_cnt_o !== exp_cnt || busy_o !== 1'b0 || wd_q_o !== 1'b0) begin
      errors++;
      $display("FAIL nowrite_done: cnt=%0d busy=%b q=%b, want %0d 0 0",
               retire_cnt_o, busy_o, wd_q_o, exp_cnt);
    end
    checks++;
    if (wd_o !== last_wd || wd_rd_o !== last_rd) begin
      errors++;
      $display("FAIL nowrite_hold_data: wd=%h rd=%0d, want %h %0d", wd_o, wd_rd_o, last_wd, last_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ready [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int   exp_pulse [4] = '{3, 7, 11, 15};
    int   idx    = 0;
    int   npulse = 0;
    logic r;
    for (int c = 0; c < 20; c++) begin
      r = res_ready_o;
      if (c < 7) begin
        checks++;
        if (r !== exp_ready[c]) begin
          errors++;
          $display("FAIL b2b_ready[c%0d]: ready=%b, want %b", c, r, exp_ready[c]);
        end
      end
      if (wd_q_o === 1'b1) begin
        checks++;
        if (npulse >= 4 || c != exp_pulse[npulse & 3] || wd_o !== 32'hA000_0000 + npulse ||
            wd_rd_o !== 5'(10 + npulse)) begin
          errors++;
          $display("FAIL b2b_pulse[%0d]: cycle=%0d wd=%h rd=%0d, want cycle %0d wd %h rd %0d",
                   npulse, c, wd_o, wd_rd_o, exp_pulse[npulse & 3],
                   32'hA000_0000 + npulse, 10 + npulse);
        end
        npulse++;
      end
      if (idx < 4) begin
        drive(1'b1, RTYPE, 5'(10 + idx), 3'd0, 32'hA000_0000 + idx, 32'h0, 32'h0);
        if (r === 1'b1) idx++;
      end else begin
        drive(1'b0, 5'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
      end
      step();
    end
    exp_cnt = exp_cnt + 32'd4;
    checks++;
    if (npulse != 4 || idx != 4 || retire_cnt_o !== exp_cnt || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_summary: pulses=%0d accepted=%0d cnt=%0d busy=%b, want 4 4 %0d 0",
               npulse, idx, retire_cnt_o, busy_o, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    int strobes = 0;
    drive(1'b1, RTYPE, 5'd4, 3'd0, 32'h0000_0044, 32'h0, 32'h0);
    step();
    drive(1'b1, RTYPE, 5'd5, 3'd0, 32'h0000_0055, 32'h0, 32'h0);
    step();
    drive(1'b0, 5'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    step();
    checks++;
    if (wd_q_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_strobe: q=%b busy=%b, want 1 1", wd_q_o, busy_o);
    end
    reset = 1'b0;
    step();
    checks++;
    if (wd_q_o !== 1'b0 || busy_o !== 1'b0 || retire_cnt_o !== 32'd0 || res_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: q=%b busy=%b cnt=%0d ready=%b, want 0 0 0 0",
               wd_q_o, busy_o, retire_cnt_o, res_ready_o);
    end
    checks++;
    if (wd_o !== 32'd0 || wd_rd_o !== 5'd0) begin
      errors++;
      $display("FAIL midreset_data: wd=%h rd=%0d, want 0 0", wd_o, wd_rd_o);
    end
    reset = 1'b1;
    exp_cnt = 32'd0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (wd_q_o !== 1'b0 || busy_o !== 1'b0) strobes++;
    end
    checks++;
    if (strobes != 0 || retire_cnt_o !== exp_cnt) begin
      errors++;
      $display("FAIL midreset_after: bad_cycles=%0d cnt=%0d, want 0 0", strobes, retire_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_data_select();
    test_no_write();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
